// File: rtl/inst_mem_loader_if.sv
// Byte-stream and instruction-memory write bus between a host byte source and inst_mem_loader.
// master = host/bench side, slave = loader side.
interface inst_mem_loader_if #(
    parameter int ADDR_W = 6
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/inst_mem_loader.sv
// Assembles a little-endian byte stream into 32-bit words and writes them into the instruction memory,
// holding the CPU in reset while loading. Optional trailing XOR checksum byte: define LOADER_CHECKSUM_EN.
module inst_mem_loader #(
    parameter int ADDR_W     = 6,
    parameter int START_ADDR = 0,
    parameter int MAX_WORDS  = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    inst_mem_loader_if.slave     bus,
    input  logic                 i_start,
    input  logic [6:0]           i_num_words,
    output logic                 o_cpu_hold,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err,
    output logic [6:0]           o_words_written
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_CSUM, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;
`endif

    state_t            r_state;
    logic              r_inReady;
    logic              r_memWe;
    logic [ADDR_W-1:0] r_memAddr;
    logic [31:0]       r_memWdata;
    logic              r_cpuHold;
    logic              r_busy;
    logic              r_done;
    logic [6:0]        r_wordsWritten;
    logic [6:0]        r_target;
    logic [1:0]        r_byteIdx;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        r_csum;
    logic              r_err;
`endif

    logic              w_accept;
    logic [6:0]        w_target;
    logic              w_lastWord;

    assign w_accept   = bus.in_valid & r_inReady;
    assign w_lastWord = (r_wordsWritten + 7'd1) == r_target;

    // A zero or oversized request means "fill the whole memory".
    always_comb begin
        w_target = i_num_words;
        if (i_num_words == 7'd0 || i_num_words > 7'(MAX_WORDS)) begin
            w_target = 7'(MAX_WORDS);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_inReady      <= 1'b0;
            r_memWe        <= 1'b0;
            r_memAddr      <= ADDR_W'(START_ADDR);
            r_memWdata     <= 32'd0;
            r_cpuHold      <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_wordsWritten <= 7'd0;
            r_target       <= 7'd0;
            r_byteIdx      <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
            r_csum         <= 8'd0;
            r_err          <= 1'b0;
`endif
        end else begin
            r_memWe <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_target       <= w_target;
                        r_wordsWritten <= 7'd0;
                        r_byteIdx      <= 2'd0;
                        r_memAddr      <= ADDR_W'(START_ADDR);
                        r_cpuHold      <= 1'b1;
                        r_busy         <= 1'b1;
                        r_inReady      <= 1'b1;
                        r_state        <= S_RECV;
`ifdef LOADER_CHECKSUM_EN
                        r_csum         <= 8'd0;
                        r_err          <= 1'b0;
`endif
                    end
                end
                S_RECV: begin
                    if (w_accept) begin
                        r_memWdata[{r_byteIdx, 3'b000} +: 8] <= bus.in_data;
                        r_byteIdx <= r_byteIdx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        r_csum    <= r_csum ^ bus.in_data;
`endif
                        if (r_byteIdx == 2'd3) begin
                            r_inReady <= 1'b0;
                            r_memWe   <= 1'b1;
                            r_state   <= S_WRITE;
                        end
                    end
                end
                // Address wraps naturally at the memory size.
                S_WRITE: begin
                    r_memAddr      <= r_memAddr + 1'b1;
                    r_wordsWritten <= r_wordsWritten + 7'd1;
                    r_byteIdx      <= 2'd0;
                    if (w_lastWord) begin
`ifdef LOADER_CHECKSUM_EN
                        r_inReady <= 1'b1;
                        r_state   <= S_CSUM;
`else
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
`endif
                    end else begin
                        r_inReady <= 1'b1;
                        r_state   <= S_RECV;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (w_accept) begin
                        if (bus.in_data != r_csum) begin
                            r_err <= 1'b1;
                        end
                        r_inReady <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    r_cpuHold <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_inReady <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready     = r_inReady;
    assign bus.mem_we       = r_memWe;
    assign bus.mem_addr     = r_memAddr;
    assign bus.mem_wdata    = r_memWdata;
    assign o_cpu_hold       = r_cpuHold;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_words_written  = r_wordsWritten;
`ifdef LOADER_CHECKSUM_EN
    assign o_err            = r_err;
`else
    assign o_err            = 1'b0;
`endif

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
Writer side of the 64x32 instruction memory: receives a byte stream over a valid/ready handshake and assembles bytes little-endian into 32-bit words. Each completed word is written into the instruction memory write port at consecutive word addresses. While loading, it holds the pipeline in reset via cpu_hold so the core never fetches a partially loaded program. It sits between the host/debug byte source and the instruction memory, alongside the RISC-V pipeline top.

Parameters:
ADDR_W, 6, word-address width of instruction memory (64 words)
START_ADDR, 0, first word address written in every session
MAX_WORDS, 64, session length limit; equals 2**ADDR_W

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse, begins a load session; ignored unless state is IDLE
num_words  in  7  words in session, sampled on accepted start; 0 means 64, values >64 clamp to 64
in_data  in  8  stream byte
in_valid  in  1  in_data valid
in_ready  out  1  loader accepts byte this cycle
mem_we  out  1  instruction memory write enable, one-cycle pulse per word
mem_addr  out  ADDR_W  word address for write
mem_wdata  out  32  assembled word
cpu_hold  out  1  high from accepted start until DONE exits; drives pipeline reset
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on session completion
err  out  1  checksum mismatch flag (see Optional Feature)
words_written  out  7  count of words written in current/last session

Behaviour:
- Reset (rst low, async): state IDLE; in_ready=0, mem_we=0, mem_addr=START_ADDR, mem_wdata=0, cpu_hold=0, busy=0, done=0, err=0, words_written=0, byte index=0.
- States: IDLE, RECV, WRITE, [CSUM], DONE.
- IDLE: start=1 -> latch num_words (0/clamp rules), words_written=0, byte index=0, mem_addr=START_ADDR, err=0, cpu_hold=1 -> RECV next cycle.
- RECV: in_ready=1. Byte accepted when in_valid & in_ready. Byte k (k=0..3) goes to mem_wdata[8k+7:8k]; byte index increments. On acceptance of byte 3 -> WRITE.
- WRITE (one cycle): in_ready=0, mem_we=1 with current mem_addr/mem_wdata. Next cycle: mem_addr+1 (mod 2**ADDR_W, wraps 63->0), words_written+1, byte index=0. If words_written+1 == latched count -> DONE (or CSUM with feature); else -> RECV.
- Latency: mem_we asserts the cycle after 4th byte accepted; peak throughput 1 byte/cycle with a 1-cycle bubble per word.
- DONE (one cycle): done=1; cpu_hold deasserts the following cycle; -> IDLE.
- in_valid while not RECV/CSUM: byte not consumed (in_ready=0); the source must hold it.
- start during non-IDLE: ignored, no effect.
- Gaps in in_valid: partial word retained indefinitely; no timeout.
- rst mid-session: immediate return to reset values; already-written words are not rolled back; cpu_hold drops.
- words_written holds final value in IDLE until next accepted start.

Optional Feature:
Macro LOADER_CHECKSUM_EN. Defined: after the last WRITE, the state goes to CSUM with in_ready=1. It accepts one byte and compares it with the XOR of all payload bytes in the session. On mismatch err=1 (sticky until next accepted start or reset). It then goes to DONE; done still pulses. Not defined: CSUM state absent, WRITE of last word goes directly to DONE, err tied to 0.

Test Plan:
- Reset then start, num_words=2, bytes 83 20 00 00 13 01 40 00 at full rate -> mem_we at addr 0 data 0x00002083, then addr 1 data 0x00400113; done pulse; words_written=2; cpu_hold high start+1 through done.
- num_words=0, 256 bytes with in_valid toggled randomly -> 64 writes, addr 0..63 in order, in_ready never high while in_valid ignored, done once.
- START_ADDR=62, num_words=3 -> writes at 62, 63, 0 (wrap), words_written=3.
- Assert rst low after 6 bytes of a 4-word session -> outputs at reset values asynchronously, exactly 1 write occurred. A new start then writes from START_ADDR.
- start pulsed mid-RECV with num_words=5 while session of 2 -> ignored, session ends after 2 words.
- LOADER_CHECKSUM_EN: 1 word 01 02 03 04 + checksum 04 -> err=0; checksum 05 -> err=1 and done still pulses; err clears on next start.
